noc_mesh_router: RTL and testbench



---
 rtl/noc_mesh_router.sv | 167 ++++++++++++++++
 tb/tb_noc_mesh_router.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_mesh_router.sv
// noc_mesh_router: five-port input-buffered 2-D mesh router, XY routing, round-robin per output.
// Define NOC_ROUTER_STATS_EN to add saturating FLIT_CNT (per output) and DROP_CNT counters.
module noc_mesh_router #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int MESH_X     = 4,
   parameter int MESH_Y     = 2,
   parameter int X_ID       = 0,
   parameter int Y_ID       = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [5*DATA_WIDTH-1:0] DATA_IN,
   input  logic [4:0]              DATA_VALID_IN,
   output logic [4:0]              FULL_OUT,
   output logic [5*DATA_WIDTH-1:0] DATA_OUT,
   output logic [4:0]              DATA_VALID_OUT,
   input  logic [4:0]              FULL_IN
`ifdef NOC_ROUTER_STATS_EN
   ,
   output logic [5*16-1:0]         FLIT_CNT,
   output logic [15:0]             DROP_CNT
`endif
);
   localparam int NP = 5;
   localparam int XW = $clog2(MESH_X);
   localparam int YW = $clog2(MESH_Y);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [2:0] P_LOCAL = 3'd0;
   localparam logic [2:0] P_EAST  = 3'd1;
   localparam logic [2:0] P_WEST  = 3'd2;
   localparam logic [2:0] P_NORTH = 3'd3;
   localparam logic [2:0] P_SOUTH = 3'd4;
   localparam logic [2:0] P_DROP  = 3'd5;

   logic [DATA_WIDTH-1:0]   mem_q [NP][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [NP][FIFO_DEPTH];
   logic [AW-1:0]           rd_ptr_q [NP], rd_ptr_d [NP];
   logic [AW-1:0]           wr_ptr_q [NP], wr_ptr_d [NP];
   logic [CW-1:0]           cnt_q [NP], cnt_d [NP];
   logic [2:0]              rr_q [NP], rr_d [NP];
   logic [NP*DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [NP-1:0]           valid_out_q, valid_out_d;
   logic [DATA_WIDTH-1:0]   head [NP];
   logic [XW-1:0]           dx [NP];
   logic [YW-1:0]           dy [NP];
   logic [2:0]              route [NP];
   logic [2:0]              cand;
   logic [NP-1:0]           nonempty, drop, pop, push;

   function automatic logic [2:0] wrap5(input int v);
      return (v >= NP) ? 3'(v - NP) : 3'(v);
   endfunction

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         head[p]     = mem_q[p][rd_ptr_q[p]];
         nonempty[p] = (cnt_q[p] != '0);
         dx[p]       = head[p][DATA_WIDTH-1 -: XW];
         dy[p]       = head[p][DATA_WIDTH-1-XW -: YW];
         if (int'(dx[p]) >= MESH_X || int'(dy[p]) >= MESH_Y) route[p] = P_DROP;
         else if (int'(dx[p]) > X_ID)                         route[p] = P_EAST;
         else if (int'(dx[p]) < X_ID)                         route[p] = P_WEST;
         else if (int'(dy[p]) > Y_ID)                         route[p] = P_NORTH;
         else if (int'(dy[p]) < Y_ID)                         route[p] = P_SOUTH;
         else                                                 route[p] = P_LOCAL;
         drop[p] = nonempty[p] && (route[p] == P_DROP);
      end
   end

   // Handshake: upstream may send while FULL_OUT is low; a flit is taken in any cycle
   // DATA_VALID_IN is high. Downstream FULL_IN high blocks new grants onto that output.
   always_comb begin
      pop         = drop;
      valid_out_d = '0;
      data_out_d  = data_out_q;
      cand        = '0;
      for (int o = 0; o < NP; o++) begin
         rr_d[o] = rr_q[o];
         for (int k = 0; k < NP; k++) begin
            cand = wrap5(int'(rr_q[o]) + k);
            if (!FULL_IN[o] && !valid_out_d[o] && nonempty[cand] && route[cand] == 3'(o)) begin
               valid_out_d[o]                          = 1'b1;
               data_out_d[o*DATA_WIDTH +: DATA_WIDTH] = head[cand];
               pop[cand]                               = 1'b1;
               rr_d[o]                                 = wrap5(int'(cand) + 1);
            end
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      for (int p = 0; p < NP; p++) begin
         push[p]     = DATA_VALID_IN[p] && (cnt_q[p] != CW'(FIFO_DEPTH) || pop[p]);
         rd_ptr_d[p] = rd_ptr_q[p] + AW'(pop[p]);
         wr_ptr_d[p] = wr_ptr_q[p] + AW'(push[p]);
         cnt_d[p]    = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
         if (push[p]) mem_d[p][wr_ptr_q[p]] = DATA_IN[p*DATA_WIDTH +: DATA_WIDTH];
         FULL_OUT[p] = (cnt_q[p] >= CW'(FIFO_DEPTH - 1));
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NP; p++) begin
            rd_ptr_q[p] <= '0;
            wr_ptr_q[p] <= '0;
            cnt_q[p]    <= '0;
            rr_q[p]     <= '0;
         end
         data_out_q  <= '0;
         valid_out_q <= '0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            rd_ptr_q[p] <= rd_ptr_d[p];
            wr_ptr_q[p] <= wr_ptr_d[p];
            cnt_q[p]    <= cnt_d[p];
            rr_q[p]     <= rr_d[p];
         end
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign DATA_OUT       = data_out_q;
   assign DATA_VALID_OUT = valid_out_q;

   // An upstream that ignores FULL_OUT loses the flit; flag it in simulation.
   for (genvar p = 0; p < NP; p++) begin : g_ovf_chk
      assert property (@(posedge clk) disable iff (rst)
         !(DATA_VALID_IN[p] && cnt_q[p] == CW'(FIFO_DEPTH) && !pop[p]))
         else $error("noc_mesh_router: flit pushed into full FIFO %0d was discarded", p);
   end

`ifdef NOC_ROUTER_STATS_EN
   logic [15:0] flit_cnt_q [NP], flit_cnt_d [NP];
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [16:0] drop_sum;

   always_comb begin
      drop_sum = {1'b0, drop_cnt_q};
      for (int p = 0; p < NP; p++) drop_sum = drop_sum + 17'(drop[p]);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int o = 0; o < NP; o++) begin
         flit_cnt_d[o] = (valid_out_d[o] && flit_cnt_q[o] != 16'hFFFF) ? flit_cnt_q[o] + 16'd1
                                                                        : flit_cnt_q[o];
         FLIT_CNT[o*16 +: 16] = flit_cnt_q[o];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int o = 0; o < NP; o++) flit_cnt_q[o] <= '0;
         drop_cnt_q <= '0;
      end else begin
         for (int o = 0; o < NP; o++) flit_cnt_q[o] <= flit_cnt_d[o];
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign DROP_CNT = drop_cnt_q;
`endif
endmodule

// File: tb/tb_noc_mesh_router.sv
// Bench for noc_mesh_router at node (1,0) of a 3x2 mesh: queue-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_noc_mesh_router;
   localparam int DW = 32, DEPTH = 4, MX = 3, MY = 2, XID = 1, YID = 0, NP = 5;
   localparam int L = 0, E = 1, W = 2, N = 3, S = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NP*DW-1:0]  data_in, data_out;
   logic [NP-1:0]     vin, full_out, valid_out, full_in;
   logic [DW-1:0]     din [NP];
`ifdef NOC_ROUTER_STATS_EN
   logic [NP*16-1:0]  flit_cnt;
   logic [15:0]       drop_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // model state
   logic [DW-1:0] mq [NP][$];
   int            rr_m [NP];
   logic [NP-1:0] exp_valid;
   logic [DW-1:0] exp_data [NP];

   always #5 clk = ~clk;

   always_comb begin
      for (int p = 0; p < NP; p++) data_in[p*DW +: DW] = din[p];
   end

   noc_mesh_router #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MESH_X(MX), .MESH_Y(MY), .X_ID(XID), .Y_ID(YID)
   ) dut (
      .clk(clk),
      .rst(rst),
      .DATA_IN(data_in),
      .DATA_VALID_IN(vin),
      .FULL_OUT(full_out),
      .DATA_OUT(data_out),
      .DATA_VALID_OUT(valid_out),
      .FULL_IN(full_in)
`ifdef NOC_ROUTER_STATS_EN
      ,
      .FLIT_CNT(flit_cnt),
      .DROP_CNT(drop_cnt)
`endif
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [1:0] dx, input logic dy, input logic [15:0] pl);
      logic [DW-1:0] f;
      f = '0;
      f[DW-1 -: 2] = dx;
      f[DW-3]      = dy;
      f[15:0]      = pl;
      return f;
   endfunction

   // Destination port straight from the XY rule; NP means the flit is dropped.
   function automatic int route_of(input logic [DW-1:0] f);
      int dx, dy;
      dx = int'(f[DW-1 -: 2]);
      dy = int'(f[DW-3]);
      if (dx >= MX || dy >= MY) return NP;
      if (dx > XID) return E;
      if (dx < XID) return W;
      if (dy > YID) return N;
      if (dy < YID) return S;
      return L;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         mq[p].delete();
         rr_m[p]     = 0;
         exp_data[p] = '0;
      end
      exp_valid = '0;
   endtask

   task automatic model_step();
      int rt [NP];
      logic [NP-1:0] taken;
      taken = '0;
      for (int p = 0; p < NP; p++) rt[p] = (mq[p].size() == 0) ? -1 : route_of(mq[p][0]);
      for (int o = 0; o < NP; o++) begin
         exp_valid[o] = 1'b0;
         if (!full_in[o]) begin
            for (int k = 0; k < NP; k++) begin
               int i;
               i = (rr_m[o] + k) % NP;
               if (!exp_valid[o] && rt[i] == o) begin
                  exp_valid[o] = 1'b1;
                  exp_data[o]  = mq[i][0];
                  taken[i]     = 1'b1;
                  rr_m[o]      = (i + 1) % NP;
               end
            end
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (rt[p] == NP) taken[p] = 1'b1;
         if (taken[p]) void'(mq[p].pop_front());
         if (vin[p] && mq[p].size() < DEPTH) mq[p].push_back(din[p]);
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         for (int o = 0; o < NP; o++) begin
            chk($sformatf("model_valid[%0d]", o), DW'(valid_out[o]), DW'(exp_valid[o]));
            chk($sformatf("model_data[%0d]", o), data_out[o*DW +: DW], exp_data[o]);
            chk($sformatf("model_full[%0d]", o), DW'(full_out[o]), DW'(mq[o].size() >= DEPTH - 1));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      @(negedge clk);
      vin = '0;
      full_in = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic one_flit(input string name, input int port, input logic [DW-1:0] f,
                           input logic [NP-1:0] exp_mask, input int out_port);
      din[port] = f;
      vin[port] = 1'b1;
      @(negedge clk);
      vin = '0;
      chk({name, "_lat1"}, DW'(valid_out), '0);
      @(negedge clk);
      chk({name, "_mask"}, DW'(valid_out), DW'(exp_mask));
      chk({name, "_data"}, data_out[out_port*DW +: DW], f);
      @(negedge clk);
   endtask

   logic [DW-1:0] rr_exp [9];
   logic [DW-1:0] exp_q [$];

   initial begin
      int k, got;
      vin = '0;
      full_in = '0;
      for (int p = 0; p < NP; p++) din[p] = '0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_valid", DW'(valid_out), '0);
      chk("reset_full", DW'(full_out), '0);
      chk("reset_data_zero", DW'(data_out == '0), 32'd1);
      rst = 1'b0;

      // straight path and XY ordering
      one_flit("straight", L, mk(2'd2, 1'b1, 16'h0a01), 5'b00010, E);
      one_flit("xy_west_first", N, mk(2'd0, 1'b1, 16'h0b01), 5'b00100, W);
      one_flit("xy_local", N, mk(2'd1, 1'b0, 16'h0b02), 5'b00001, L);
      one_flit("xy_north", S, mk(2'd1, 1'b1, 16'h0b03), 5'b01000, N);

      // contention: three inputs hold three flits each for EAST
      do_reset();
      full_in[E] = 1'b1;
      for (int j = 0; j < 3; j++) begin
         din[L] = mk(2'd2, 1'b0, 16'h0100 + 16'(j));
         din[W] = mk(2'd2, 1'b1, 16'h0200 + 16'(j));
         din[S] = mk(2'd2, 1'b0, 16'h0300 + 16'(j));
         vin = 5'b10101;
         @(negedge clk);
      end
      vin = '0;
      @(negedge clk);
      chk("rr_full_out", DW'(full_out), DW'(5'b10101));
      rr_exp[0] = mk(2'd2, 1'b0, 16'h0100);
      rr_exp[1] = mk(2'd2, 1'b1, 16'h0200);
      rr_exp[2] = mk(2'd2, 1'b0, 16'h0300);
      rr_exp[3] = mk(2'd2, 1'b0, 16'h0101);
      rr_exp[4] = mk(2'd2, 1'b1, 16'h0201);
      rr_exp[5] = mk(2'd2, 1'b0, 16'h0301);
      rr_exp[6] = mk(2'd2, 1'b0, 16'h0102);
      rr_exp[7] = mk(2'd2, 1'b1, 16'h0202);
      rr_exp[8] = mk(2'd2, 1'b0, 16'h0302);
      full_in[E] = 1'b0;
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         chk($sformatf("rr_valid_%0d", j), DW'(valid_out[E]), 32'd1);
         chk($sformatf("rr_order_%0d", j), data_out[E*DW +: DW], rr_exp[j]);
      end
      @(negedge clk);
      chk("rr_done", DW'(valid_out), '0);
`ifdef NOC_ROUTER_STATS_EN
      chk("rr_flit_cnt_east", DW'(flit_cnt[E*16 +: 16]), 32'd9);
`endif

      // backpressure: LOCAL streams into a blocked EAST, sender honours FULL_OUT
      do_reset();
      full_in[E] = 1'b1;
      k = 0;
      got = 0;
      for (int c = 0; c < 60 && got < 8; c++) begin
         if (valid_out[E]) begin
            chk("bp_expected_pending", DW'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("bp_order", data_out[E*DW +: DW], exp_q.pop_front());
            got++;
         end
         if (c == 10) begin
            chk("bp_full_held", DW'(full_out[L]), 32'd1);
            chk("bp_accepted_blocked", DW'(k), 32'd3);
         end
         if (c == 12) full_in[E] = 1'b0;
         if (k < 8 && !full_out[L]) begin
            din[L] = mk(2'd2, 1'b0, 16'h0400 + 16'(k));
            vin[L] = 1'b1;
            exp_q.push_back(din[L]);
            k++;
         end else begin
            vin[L] = 1'b0;
         end
         @(negedge clk);
      end
      vin = '0;
      chk("bp_all_out", DW'(got), 32'd8);

      // out-of-range destination followed by a normal flit
      do_reset();
      din[L] = mk(2'd3, 1'b0, 16'h0d01);
      vin[L] = 1'b1;
      @(negedge clk);
      din[L] = mk(2'd0, 1'b0, 16'h0d02);
      @(negedge clk);
      vin = '0;
      chk("drop_no_out_n2", DW'(valid_out), '0);
      @(negedge clk);
      chk("drop_next_mask", DW'(valid_out), DW'(5'b00100));
      chk("drop_next_data", data_out[W*DW +: DW], mk(2'd0, 1'b0, 16'h0d02));
`ifdef NOC_ROUTER_STATS_EN
      chk("drop_cnt", DW'(drop_cnt), 32'd1);
`endif

      // reset in the middle of traffic
      do_reset();
      full_in[E] = 1'b1;
      din[L] = mk(2'd2, 1'b0, 16'h0e01);
      vin[L] = 1'b1;
      @(negedge clk);
      din[L] = mk(2'd2, 1'b0, 16'h0e02);
      din[N] = mk(2'd0, 1'b0, 16'h0e03);
      vin = 5'b01001;
      @(negedge clk);
      vin = '0;
      @(negedge clk);
      chk("rm_pre_valid", DW'(valid_out), DW'(5'b00100));
      #2 rst = 1'b1;
      #1;
      chk("rm_async_valid", DW'(valid_out), '0);
      chk("rm_async_data_zero", DW'(data_out == '0), 32'd1);
      chk("rm_async_full", DW'(full_out), '0);
      @(negedge clk);
      rst = 1'b0;
      full_in = '0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk($sformatf("rm_no_stale_%0d", j), DW'(valid_out), '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
